mem_access_unit: RTL and testbench

Load/store initiator that sits between the multi-cycle CPU control/datapath and the word-organised data memory (10-bit word address, 32-bit write data, single write strobe, combinational read, write on rising clk).
- Converts CPU byte, halfword and word loads and stores into word-only memory transactions.
- Stores narrower than a word use read-modify-write.
- Loads are sign- or zero-extended.
- Misaligned or illegal requests are flagged and never reach the memory.

---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator: turns CPU byte/half/word accesses into word-only
// memory transactions, merging sub-word stores by read-modify-write.

module mau_lane (
    input  logic       en_i,      // this lane is overwritten by the store
    input  logic [7:0] old_i,     // byte read back from memory
    input  logic [7:0] new_i,     // candidate byte from store data
    output logic [7:0] byte_o
);
    assign byte_o = en_i ? new_i : old_i;
endmodule

module mem_access_unit #(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             wr,
    input  logic [1:0]       size,
    input  logic             uext,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      rdata,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    output logic             dm_we,
    input  logic [31:0]      dm_rdata
);
    localparam int NUM_LANES = 4;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_ERR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             wr_q, wr_d;
    logic [1:0]       size_q, size_d;
    logic             uext_q, uext_d;
    logic [DM_AW+1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      mbuf_q, mbuf_d;

    // Address bits above the data-memory window are dropped (4 KiB wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:DM_AW+2];

    logic bad_req;
    assign bad_req = (size == 2'b11)
                   | ((size == SZ_HALF) & addr[0])
                   | ((size == SZ_WORD) & (|addr[1:0]));

    // Load lane extraction and extension
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (size_q)
            SZ_BYTE: ld_ext = {{24{~uext_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{~uext_q & ld_half[15]}}, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    // Store merge: each lane keeps its old byte unless the access covers it
    logic [NUM_LANES-1:0][7:0] old_lane, new_lane, mrg_lane;
    logic [NUM_LANES-1:0]      lane_en;

    assign old_lane = mbuf_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LANE = i[1:0];
        assign lane_en[i]  = ((size_q == SZ_BYTE) & (addr_q[1:0] == LANE))
                           | ((size_q == SZ_HALF) & (addr_q[1] == LANE[1]));
        // a half places its low byte in even lanes, high byte in odd lanes
        assign new_lane[i] = (size_q == SZ_HALF) ? wdata_q[8*(i%2) +: 8]
                                                 : wdata_q[7:0];
        mau_lane u_lane (
            .en_i   (lane_en[i]),
            .old_i  (old_lane[i]),
            .new_i  (new_lane[i]),
            .byte_o (mrg_lane[i])
        );
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        uext_d  = uext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mbuf_d  = mbuf_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    uext_d  = uext;
                    addr_d  = addr[DM_AW+1:0];
                    wdata_d = wdata;
                    if (bad_req)
                        state_d = S_ERR;
                    else if (wr && size == SZ_WORD)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (wr_q) begin
                    mbuf_d  = dm_rdata;
                    state_d = S_WR;
                end else begin
                    rdata_d = ld_ext;
                    state_d = S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            S_ERR:   state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uext_q  <= uext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mbuf_q  <= mbuf_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE) | (state_q == S_ERR);
    assign err      = (state_q == S_ERR);
    assign dm_we    = (state_q == S_WR);
    assign rdata    = rdata_q;
    assign dm_addr  = addr_q[DM_AW+1:2];
    assign dm_wdata = (size_q == SZ_WORD) ? wdata_q : mrg_lane;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.

module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, dm_we;
    logic [31:0] rdata, dm_wdata, dm_rdata;
    logic [9:0]  dm_addr;

    logic [31:0] mem [0:1023];
    int          we_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr] <= dm_wdata;
            we_cnt <= we_cnt + 1;
        end
    end
    assign dm_rdata = mem[dm_addr];

    mem_access_unit #(.DM_AW(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wr       (wr),
        .size     (size),
        .uext     (uext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .dm_rdata (dm_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request; returns 1 ns after the accepting edge N.
    task automatic issue(input logic w, input logic [1:0] sz, input logic ue,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; uext = ue; addr = a; wdata = d;
        step();
        req = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic ue,
                           input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, sz, ue, a, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_early_done"}, {31'b0, done}, 32'd0);
        step();
        chk({tag, "_done"}, {30'b0, done, err}, 32'd2);
        chk({tag, "_rdata"}, rdata, exp);
        step();
        chk({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
    endtask

    task automatic do_wstore(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input int idx);
        int w0;
        w0 = we_cnt;
        issue(1'b1, 2'b10, 1'b0, a, d);
        chk({tag, "_we"}, {31'b0, dm_we}, 32'd1);
        chk({tag, "_dm_addr"}, {22'b0, dm_addr}, idx);
        chk({tag, "_dm_wdata"}, dm_wdata, d);
        step();
        chk({tag, "_done"}, {30'b0, done, err}, 32'd2);
        chk({tag, "_mem"}, mem[idx], d);
        chk({tag, "_we_cnt"}, we_cnt - w0, 32'd1);
        step();
        chk({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
    endtask

    task automatic do_sstore(input string tag, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input int idx, input logic [31:0] exp);
        int w0;
        w0 = we_cnt;
        issue(1'b1, sz, 1'b0, a, d);
        chk({tag, "_rd_phase"}, {29'b0, busy, dm_we, done}, 32'd4);
        step();
        chk({tag, "_wr_phase"}, {29'b0, busy, dm_we, done}, 32'd6);
        step();
        chk({tag, "_done"}, {30'b0, done, err}, 32'd2);
        chk({tag, "_mem"}, mem[idx], exp);
        chk({tag, "_we_cnt"}, we_cnt - w0, 32'd1);
        step();
        chk({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
    endtask

    task automatic do_err(input string tag, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] rd_exp);
        int w0;
        w0 = we_cnt;
        issue(w, sz, 1'b0, a, 32'hFFFF_FFFF);
        chk({tag, "_done_err"}, {29'b0, busy, done, err}, 32'd7);
        chk({tag, "_no_we"}, {31'b0, dm_we}, 32'd0);
        step();
        chk({tag, "_idle"}, {29'b0, busy, done, err}, 32'd0);
        chk({tag, "_we_cnt"}, we_cnt - w0, 32'd0);
        chk({tag, "_rdata_kept"}, rdata, rd_exp);
    endtask

    initial begin
        #12;
        chk("rst_ctrl", {28'b0, busy, done, err, dm_we}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dm_addr", {22'b0, dm_addr}, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // word store then load
        do_wstore("t1_st", 32'h0000_0010, 32'h1234_5678, 4);
        do_load("t1_ld", 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678);

        // sub-word read-modify-write
        do_wstore("t2_init", 32'h0000_0010, 32'hAABB_CCDD, 4);
        do_sstore("t2_byte", 2'b00, 32'h0000_0012, 32'hFFFF_FF11, 4, 32'hAA11_CCDD);
        do_sstore("t2_half", 2'b01, 32'h0000_0012, 32'hFFFF_5566, 4, 32'h5566_CCDD);
        do_sstore("t2_b0", 2'b00, 32'h0000_0010, 32'h0000_0099, 4, 32'h5566_CC99);

        // sign/zero extension
        do_wstore("t3_init", 32'h0000_0010, 32'h80FF_7F01, 4);
        do_load("t3_b11s", 2'b00, 1'b0, 32'h0000_0011, 32'h0000_007F);
        do_load("t3_b12s", 2'b00, 1'b0, 32'h0000_0012, 32'hFFFF_FFFF);
        do_load("t3_b13z", 2'b00, 1'b1, 32'h0000_0013, 32'h0000_0080);
        do_load("t3_h12z", 2'b01, 1'b1, 32'h0000_0012, 32'h0000_80FF);
        do_load("t3_h12s", 2'b01, 1'b0, 32'h0000_0012, 32'hFFFF_80FF);
        do_load("t3_h10s", 2'b01, 1'b0, 32'h0000_0010, 32'h0000_7F01);

        // misaligned / illegal
        do_err("t4_word13", 1'b0, 2'b10, 32'h0000_0013, 32'h0000_7F01);
        do_err("t4_half11", 1'b1, 2'b01, 32'h0000_0011, 32'h0000_7F01);
        do_err("t4_size3", 1'b1, 2'b11, 32'h0000_0010, 32'h0000_7F01);
        chk("t4_mem_intact", mem[4], 32'h80FF_7F01);

        // address wrap and req held during busy
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; uext = 1'b0;
        addr = 32'h0000_1004; wdata = 32'hDEAD_BEEF;
        step();
        wr = 1'b0;
        chk("t5_we", {31'b0, dm_we}, 32'd1);
        chk("t5_wrap_addr", {22'b0, dm_addr}, 32'd1);
        step();
        chk("t5_done", {30'b0, done, err}, 32'd2);
        chk("t5_mem1", mem[1], 32'hDEAD_BEEF);
        step();
        chk("t5_back_idle", {30'b0, busy, done}, 32'd0);
        step();
        req = 1'b0;
        chk("t5_accepted", {31'b0, busy}, 32'd1);
        chk("t5_no_we", {31'b0, dm_we}, 32'd0);
        step();
        chk("t5_ld_done", {30'b0, done, err}, 32'd2);
        chk("t5_ld_rdata", rdata, 32'hDEAD_BEEF);
        step();
        chk("t5_idle", {30'b0, busy, done}, 32'd0);

        // reset during the read phase of a byte store
        begin
            int w0;
            w0 = we_cnt;
            issue(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_0055);
            chk("t6_in_rd", {30'b0, busy, dm_we}, 32'd2);
            rst_n = 1'b0;
            #1;
            chk("t6_rst_ctrl", {28'b0, busy, done, err, dm_we}, 32'd0);
            chk("t6_rst_rdata", rdata, 32'h0);
            chk("t6_rst_dm_addr", {22'b0, dm_addr}, 32'h0);
            chk("t6_rst_dm_wdata", dm_wdata, 32'h0);
            step();
            step();
            chk("t6_no_write", we_cnt - w0, 32'd0);
            chk("t6_mem_intact", mem[4], 32'h80FF_7F01);
            chk("t6_no_done", {30'b0, done, busy}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        do_load("t6_ld", 2'b10, 1'b0, 32'h0000_0010, 32'h80FF_7F01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
